// File: rtl/legup_lock_arbiter_if.sv
// Lock handshake plus Avalon-MM status port for legup_lock_arbiter.
// slave = arbiter side, master = requesters/processor side.
interface legup_lock_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] rel;
  logic [N_REQ-1:0] grant;
  logic             busy;
  logic [IDX_W-1:0] owner;
  logic             timeout_irq;
  logic             avs_s1_address;
  logic             avs_s1_read;
  logic [31:0]      avs_s1_readdata;
  logic             avs_s1_waitrequest;

  modport slave (
    input  req, rel, avs_s1_address, avs_s1_read,
    output grant, busy, owner, timeout_irq, avs_s1_readdata, avs_s1_waitrequest
  );
  modport master (
    output req, rel, avs_s1_address, avs_s1_read,
    input  grant, busy, owner, timeout_irq, avs_s1_readdata, avs_s1_waitrequest
  );
endinterface

// File: rtl/legup_lock_arbiter.sv
// Round-robin hardware lock arbiter with read-only Avalon status.
// Optional forced revocation of long holds: define LOCK_ARB_TIMEOUT_EN.
module legup_lock_arbiter #(
  parameter int N_REQ       = 4,
  parameter int IDX_W       = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               reset_n,
  legup_lock_arbiter_if.slave bus
);

  if (N_REQ < 2 || N_REQ > 16 || (1 << IDX_W) < N_REQ || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("legup_lock_arbiter: illegal parameter set");
  end

  typedef enum logic {FREE, HELD} state_e;

  state_e           state_q;
  logic [N_REQ-1:0] grant_q, win_oh;
  logic [IDX_W-1:0] owner_q, rr_ptr_q, win_idx, rr_next;
  logic             busy_q, found, rel_own, rd0, timeout_hit, tflag, tirq;
  logic [31:0]      grant_cnt_q, status0;

  // Scan upward from rr_ptr, wrapping; the first set request wins.
  always_comb begin : p_scan
    logic [N_REQ-1:0] req_sh;
    int s;
    found   = 1'b0;
    win_oh  = '0;
    win_idx = '0;
    req_sh  = '0;
    s       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      s = int'(rr_ptr_q) + k;
      if (s >= N_REQ) s = s - N_REQ;
      req_sh = bus.req >> s;
      if (!found && req_sh[0]) begin
        found   = 1'b1;
        win_idx = IDX_W'(s);
        win_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << s;
      end
    end
  end

  // grant_q is one-hot at the owner, so this is rel[owner] gated by HELD.
  assign rel_own = |(bus.rel & grant_q);
  assign rr_next = (owner_q == IDX_W'(N_REQ-1)) ? '0 : owner_q + 1'b1;
  assign rd0     = bus.avs_s1_read && !bus.avs_s1_address;

`ifdef LOCK_ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(TIMEOUT_CYC) + 1;
  logic [HOLD_W-1:0] hold_q;
  logic              tflag_q, tirq_q;

  // A coincident release wins over revocation.
  assign timeout_hit = (state_q == HELD) && (hold_q == HOLD_W'(TIMEOUT_CYC-1)) && !rel_own;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q  <= '0;
      tflag_q <= 1'b0;
      tirq_q  <= 1'b0;
    end else begin
      tirq_q <= timeout_hit;
      hold_q <= (state_q == HELD) ? hold_q + 1'b1 : '0;
      if (timeout_hit)  tflag_q <= 1'b1;
      else if (rd0)     tflag_q <= 1'b0;
    end
  end

  assign tflag = tflag_q;
  assign tirq  = tirq_q;
`else
  assign timeout_hit = 1'b0;
  assign tflag       = 1'b0;
  assign tirq        = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FREE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      owner_q     <= '0;
      grant_cnt_q <= '0;
    end else begin
      case (state_q)
        FREE: if (found) begin
          state_q     <= HELD;
          grant_q     <= win_oh;
          busy_q      <= 1'b1;
          owner_q     <= win_idx;
          grant_cnt_q <= grant_cnt_q + 1'b1;
        end
        HELD: if (rel_own || timeout_hit) begin
          state_q  <= FREE;
          grant_q  <= '0;
          busy_q   <= 1'b0;
          owner_q  <= '0;
          rr_ptr_q <= rr_next;
        end
        default: state_q <= FREE;
      endcase
    end
  end

  always_comb begin
    status0              = '0;
    status0[31]          = busy_q;
    status0[30]          = tflag;
    status0[IDX_W-1:0]   = owner_q;
  end

  assign bus.grant              = grant_q;
  assign bus.busy               = busy_q;
  assign bus.owner              = owner_q;
  assign bus.timeout_irq        = tirq;
  assign bus.avs_s1_readdata    = bus.avs_s1_address ? grant_cnt_q : status0;
  assign bus.avs_s1_waitrequest = 1'b0;

endmodule

// File: tb/tb_legup_lock_arbiter.sv
// Directed plus randomized check of legup_lock_arbiter against a queue-free
// behavioural lock model (owner index, rotating pointer, grant counter).
module tb_legup_lock_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  legup_lock_arbiter_if #(.N_REQ(N), .IDX_W(W)) bus();

  legup_lock_arbiter #(.N_REQ(N), .IDX_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model: m_owner = -1 means the lock is free
  int          m_owner, m_rr, m_held;
  logic [31:0] m_cnt;
  bit          m_flag, m_irq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_grant();
    return (m_owner < 0) ? 32'd0 : (32'd1 << m_owner);
  endfunction

  function automatic logic [31:0] exp_rd();
    logic [31:0] v;
    if (bus.avs_s1_address) return m_cnt;
    v = 32'd0;
    v[31] = (m_owner >= 0);
    v[30] = m_flag;
    if (m_owner >= 0) v = v | 32'(m_owner);
    return v;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_rr = 0; m_cnt = 0; m_flag = 0; m_irq = 0; m_held = 0;
  endtask

  // One rising edge of the abstract lock, using the inputs currently driven.
  task automatic model_step();
    logic [N-1:0] rq, rl;
    rq = bus.req;
    rl = bus.rel;
    m_irq = 0;
    if (bus.avs_s1_read && !bus.avs_s1_address) m_flag = 0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (m_owner < 0 && ((rq >> idx) & 1'b1)) begin
          m_owner = idx;
          m_cnt   = m_cnt + 1;
          m_held  = 0;
        end
      end
    end else if ((rl >> m_owner) & 1'b1) begin
      m_rr = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      m_held++;
`ifdef LOCK_ARB_TIMEOUT_EN
      if (m_held == TO) begin
        m_rr = (m_owner + 1) % N;
        m_owner = -1;
        m_irq = 1;
        m_flag = 1;
      end
`endif
    end
  endtask

  // Called just after a falling edge with inputs driven: check, model, advance.
  task automatic tick();
    #1;
    chk("grant", 32'(bus.grant), exp_grant());
    chk("busy",  32'(bus.busy),  32'(m_owner >= 0));
    chk("owner", 32'(bus.owner), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    chk("irq",   32'(bus.timeout_irq), 32'(m_irq));
    if (bus.avs_s1_read) chk("rdata", bus.avs_s1_readdata, exp_rd());
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.req = '0; bus.rel = '0; bus.avs_s1_read = 1'b0; bus.avs_s1_address = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    bus.req = '0; bus.rel = '0; bus.avs_s1_read = 1'b0; bus.avs_s1_address = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    // reset state
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_owner", 32'(bus.owner), 0);
    chk("rst_irq",   32'(bus.timeout_irq), 0);
    chk("rst_wait",  32'(bus.avs_s1_waitrequest), 0);
    bus.avs_s1_read = 1'b1;
    #1 chk("rst_rd0", bus.avs_s1_readdata, 0);
    bus.avs_s1_address = 1'b1;
    #1 chk("rst_rd1", bus.avs_s1_readdata, 0);
    bus.avs_s1_read = 1'b0; bus.avs_s1_address = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // single requester
    bus.req = 4'b0100;
    tick();
    chk("single_grant", 32'(bus.grant), 32'b0100);
    chk("single_owner", 32'(bus.owner), 2);
    bus.req = '0;
    repeat (3) tick();
    bus.rel = 4'b0100;
    tick();
    bus.rel = '0;
    chk("single_rel", 32'(bus.grant), 0);
    bus.avs_s1_read = 1'b1; bus.avs_s1_address = 1'b1;
    #1 chk("single_cnt", bus.avs_s1_readdata, 1);
    tick();
    bus.avs_s1_read = 1'b0; bus.avs_s1_address = 1'b0;

    // round-robin fairness from rr_ptr 0
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_order", 32'(bus.owner), 32'(order[i]));
      tick(); tick();
      bus.rel = bus.grant;
      tick();
      bus.rel = '0;
      chk("rr_gap", 32'(bus.busy), 0);
    end
    bus.req = '0;
    tick();

    // foreign release is ignored (rr now 1)
    bus.req = 4'b0010;
    tick();
    bus.req = '0; bus.rel = 4'b1000;
    tick();
    bus.rel = '0;
    chk("foreign_rel", 32'(bus.grant), 32'b0010);
    bus.rel = 4'b0010;
    tick();
    bus.rel = '0;

    // withdrawal: rr ends at 0 after owner 3, but 0 has dropped its request
    bus.req = 4'b1000;
    tick();
    bus.req = 4'b1011;
    tick();
    bus.req = 4'b1010;
    tick();
    bus.req = 4'b0010; bus.rel = 4'b1000;
    tick();
    bus.rel = '0;
    tick();
    chk("withdraw_skip", 32'(bus.owner), 1);
    bus.req = '0; bus.rel = 4'b0010;
    tick();
    bus.rel = '0;

    // asynchronous reset while requester 3 holds
    bus.req = 4'b1000;
    tick();
    bus.req = '0;
    tick();
    chk("pre_rst_grant", 32'(bus.grant), 32'b1000);
    #2 reset_n = 1'b0;
    model_reset();
    #1 chk("async_rst_grant", 32'(bus.grant), 0);
    chk("async_rst_busy", 32'(bus.busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.req = 4'b1010;
    tick();
    chk("post_rst_first", 32'(bus.owner), 1);
    bus.req = '0;

    // hold without release
    do_reset();
    bus.req = 4'b0001;
    tick();
    bus.req = '0;
    repeat (TO) tick();
`ifdef LOCK_ARB_TIMEOUT_EN
    chk("to_grant", 32'(bus.grant), 0);
    chk("to_irq",   32'(bus.timeout_irq), 1);
    bus.avs_s1_read = 1'b1;
    #1 chk("to_flag_set", 32'(bus.avs_s1_readdata[30]), 1);
    tick();
    chk("to_irq_pulse", 32'(bus.timeout_irq), 0);
    #1 chk("to_flag_clr", 32'(bus.avs_s1_readdata[30]), 0);
    tick();
    bus.avs_s1_read = 1'b0;
`else
    repeat (12) tick();
    chk("hold_forever", 32'(bus.grant), 32'b0001);
    chk("no_irq", 32'(bus.timeout_irq), 0);
`endif

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      logic [N-1:0] rl;
      bus.req = N'($urandom_range(0, 15));
      rl = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0 && m_owner >= 0) rl = rl | N'(1 << m_owner);
      bus.rel = rl;
      bus.avs_s1_read    = 1'($urandom_range(0, 1));
      bus.avs_s1_address = 1'($urandom_range(0, 1));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
